// File: rtl/mul_pkg.sv
// Shared types and size helpers for the tiled sequential multipliers.
// Sizes are derived from the result width; the defaults match the CNN 12x8 datapath.
package mul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic int ceil_div8(input int w);
      return (w + 7) / 8;
   endfunction

   function automatic int calc_ext_w(input int p_w);
      return 8 * ceil_div8(p_w);
   endfunction

   function automatic int calc_tiles(input int p_w);
      int n;
      n = ceil_div8(p_w);
      return n * (n + 1) / 2;
   endfunction

   localparam int DEF_P_W   = 20;
   localparam int DEF_N     = ceil_div8(DEF_P_W);
   localparam int DEF_EXT_W = calc_ext_w(DEF_P_W);
   localparam int DEF_T     = calc_tiles(DEF_P_W);

endpackage

// File: rtl/tile_mul_8x8.sv
// Combinational 8x8 unsigned tile multiplier with optional low-bit truncation.
// Shared by the sequential multiplier and the planned parallel variants.
module tile_mul_8x8 (
   input  logic [7:0]  a8,
   input  logic [7:0]  b8,
   input  logic        apx,
   input  logic [3:0]  drop,
   output logic [15:0] p16
);

   logic [15:0] prod;
   logic [15:0] mask;

   assign prod = a8 * b8;
   assign mask = 16'hFFFF << drop;
   assign p16  = apx ? (prod & mask) : prod;

endmodule

// File: rtl/mul_tile_seq.sv
// Signed A_W x B_W multiplier that walks one 8x8 tile per cycle over the
// tiles feeding the low P_W bits, accumulating shifted partial products.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for an operand transaction
// CALC   | one tile (i,j) added into the accumulator per cycle
// DONE   | result held on p until the downstream handshake
module mul_tile_seq
   import mul_pkg::*;
#(
   parameter int A_W      = 12,
   parameter int B_W      = 8,
   parameter int P_W      = 20,
   parameter int APX_DROP = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   input  logic           approx_en,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [P_W-1:0] p
);

   localparam int N     = ceil_div8(P_W);
   localparam int EXT_W = calc_ext_w(P_W);
   localparam int T     = calc_tiles(P_W);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(T + 1);

   state_e state_q, state_d;

   logic [EXT_W-1:0] a_q, a_d;
   logic [EXT_W-1:0] b_q, b_d;
   logic [EXT_W-1:0] acc_q, acc_d;
   logic             approx_q, approx_d;
   logic [IDX_W-1:0] i_q, i_d;
   logic [IDX_W-1:0] j_q, j_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [P_W-1:0]   p_q, p_d;

   logic signed [A_W-1:0]   a_s;
   logic signed [B_W-1:0]   b_s;
   logic signed [EXT_W-1:0] a_ext;
   logic signed [EXT_W-1:0] b_ext;
   logic                    accept;
   logic                    last_tile;
   logic [7:0]              a_byte;
   logic [7:0]              b_byte;
   logic                    tile_apx;
   logic [15:0]             tile_p16;
   logic [EXT_W+15:0]       tile_wide;
   logic [EXT_W-1:0]        tile_sh;

   assign a_s   = a;
   assign b_s   = b;
   assign a_ext = EXT_W'(a_s);
   assign b_ext = EXT_W'(b_s);

   assign accept    = (state_q == S_IDLE) && in_valid;
   assign last_tile = (cnt_q == CNT_W'(T - 1));

   assign a_byte   = a_q[8*i_q +: 8];
   assign b_byte   = b_q[8*j_q +: 8];
   assign tile_apx = approx_q && (i_q == '0) && (j_q == '0);

   tile_mul_8x8 u_tile (
      .a8   (a_byte),
      .b8   (b_byte),
      .apx  (tile_apx),
      .drop (4'(APX_DROP)),
      .p16  (tile_p16)
   );

   // Widened by 16 so the shift never loses bits before truncation to EXT_W.
   assign tile_wide = {{EXT_W{1'b0}}, tile_p16} << (8 * (i_q + j_q));
   assign tile_sh   = tile_wide[EXT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)  state_d = S_CALC;
         S_CALC:  if (last_tile) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      p         = p_q;
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      approx_d = approx_q;
      i_d      = i_q;
      j_d      = j_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      if (accept) begin
         a_d      = a_ext;
         b_d      = b_ext;
         approx_d = approx_en;
         acc_d    = '0;
         i_d      = '0;
         j_d      = '0;
         cnt_d    = '0;
      end else if (state_q == S_CALC) begin
         acc_d = acc_q + tile_sh;
         cnt_d = cnt_q + CNT_W'(1);
         // j outer, i inner over the triangle i+j < N
         if (i_q == IDX_W'(N - 1) - j_q) begin
            i_d = '0;
            j_d = j_q + IDX_W'(1);
         end else begin
            i_d = i_q + IDX_W'(1);
         end
         if (last_tile) begin
            p_d = acc_d[P_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         approx_q <= 1'b0;
         i_q      <= '0;
         j_q      <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         approx_q <= approx_d;
         i_q      <= i_d;
         j_q      <= j_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
      end
   end

endmodule
